// File: rtl/row_stream_packer_if.sv
// Handshake bundle for row_stream_packer: the upstream word stream and the
// downstream row valid/ready channel.
interface row_stream_packer_if #(
    parameter int WIDTH       = 28,
    parameter int HEIGHT      = 28,
    parameter int IN_CHANNELS = 1,
    parameter int VALUE_BITS  = 8,
    parameter int DATA_BITS   = 32
);
    localparam int IDX_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic [DATA_BITS-1:0]                               in_data_i;
    logic                                               in_valid_i;
    logic                                               upstream_stall_o;
    logic [WIDTH-1:0][IN_CHANNELS-1:0][VALUE_BITS-1:0]  out_row_o;
    logic                                               out_row_valid_o;
    logic                                               out_row_ready_i;
    logic [IDX_W-1:0]                                   row_index_o;
    logic                                               last_row_o;

    modport slave (
        input  in_data_i,
        input  in_valid_i,
        output upstream_stall_o,
        output out_row_o,
        output out_row_valid_o,
        input  out_row_ready_i,
        output row_index_o,
        output last_row_o
    );

    modport master (
        output in_data_i,
        output in_valid_i,
        input  upstream_stall_o,
        input  out_row_o,
        input  out_row_valid_o,
        output out_row_ready_i,
        input  row_index_o,
        input  last_row_o
    );
endinterface

// File: rtl/row_stream_packer.sv
// Ping-pong row deserializer: packs a raster word stream into full rows.
// Optional macro ROW_PACKER_SATURATE_EN clamps signed input words instead of truncating.
module row_stream_packer #(
    parameter int WIDTH       = 28,
    parameter int HEIGHT      = 28,
    parameter int IN_CHANNELS = 1,
    parameter int VALUE_BITS  = 8,
    parameter int DATA_BITS   = 32
) (
    input  logic              clock_i,
    input  logic              reset_i,
    row_stream_packer_if.slave bus
);
    localparam int CH_W  = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int IDX_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef logic [WIDTH-1:0][IN_CHANNELS-1:0][VALUE_BITS-1:0] row_t;
    typedef enum logic { OUT_EMPTY, OUT_HELD } out_state_e;
    typedef enum logic { BUF_FILLING, BUF_FULL } buf_state_e;

    out_state_e        out_state_q, out_state_d;
    buf_state_e        buf_state_q, buf_state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
    logic [IDX_W-1:0]  row_index_q, row_index_d;
    row_t              fill_buf_q, fill_buf_d;
    row_t              out_row_q, out_row_d;

    logic [VALUE_BITS-1:0] value;
    row_t                  merged;
    logic                  accept;
    logic                  handshake;
    logic                  ch_last;
    logic                  col_last;
    logic                  row_done;
    logic [IDX_W-1:0]      fill_idx_next;

`ifdef ROW_PACKER_SATURATE_EN
    localparam logic signed [DATA_BITS:0] VAL_MAX =
        {{(DATA_BITS + 1 - VALUE_BITS){1'b0}}, {VALUE_BITS{1'b1}}};
    logic signed [DATA_BITS:0] wide_word;

    always_comb begin
        wide_word = $signed({bus.in_data_i[DATA_BITS-1], bus.in_data_i});
        value     = bus.in_data_i[VALUE_BITS-1:0];
        if (wide_word < 0) begin
            value = '0;
        end else if (wide_word > VAL_MAX) begin
            value = '1;
        end
    end
`else
    logic unused_word_bits;

    assign unused_word_bits = ^bus.in_data_i;
    assign value            = bus.in_data_i[VALUE_BITS-1:0];
`endif

    assign accept        = bus.in_valid_i && (buf_state_q == BUF_FILLING);
    assign handshake     = (out_state_q == OUT_HELD) && bus.out_row_ready_i;
    assign ch_last       = (ch_q == CH_W'(IN_CHANNELS - 1));
    assign col_last      = (col_q == COL_W'(WIDTH - 1));
    assign row_done      = accept && ch_last && col_last;
    assign fill_idx_next = (fill_idx_q == IDX_W'(HEIGHT - 1)) ? '0 : fill_idx_q + IDX_W'(1);

    always_comb begin
        merged              = fill_buf_q;
        merged[col_q][ch_q] = value;
    end

    // The fill index advances only when a row moves into the output register,
    // so while the fill buffer is FULL it still names the buffered row.
    always_comb begin
        out_state_d = out_state_q;
        buf_state_d = buf_state_q;
        ch_d        = ch_q;
        col_d       = col_q;
        fill_idx_d  = fill_idx_q;
        row_index_d = row_index_q;
        fill_buf_d  = fill_buf_q;
        out_row_d   = out_row_q;

        if (handshake) begin
            out_state_d = OUT_EMPTY;
        end

        if (accept) begin
            fill_buf_d = merged;
            if (ch_last) begin
                ch_d  = '0;
                col_d = col_last ? '0 : col_q + COL_W'(1);
            end else begin
                ch_d = ch_q + CH_W'(1);
            end
        end

        if (row_done) begin
            if ((out_state_q == OUT_EMPTY) || handshake) begin
                out_row_d   = merged;
                row_index_d = fill_idx_q;
                fill_idx_d  = fill_idx_next;
                out_state_d = OUT_HELD;
            end else begin
                buf_state_d = BUF_FULL;
            end
        end else if ((buf_state_q == BUF_FULL) && handshake) begin
            out_row_d   = fill_buf_q;
            row_index_d = fill_idx_q;
            fill_idx_d  = fill_idx_next;
            out_state_d = OUT_HELD;
            buf_state_d = BUF_FILLING;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            out_state_q <= OUT_EMPTY;
            buf_state_q <= BUF_FILLING;
            ch_q        <= '0;
            col_q       <= '0;
            fill_idx_q  <= '0;
            row_index_q <= '0;
            fill_buf_q  <= '0;
            out_row_q   <= '0;
        end else begin
            out_state_q <= out_state_d;
            buf_state_q <= buf_state_d;
            ch_q        <= ch_d;
            col_q       <= col_d;
            fill_idx_q  <= fill_idx_d;
            row_index_q <= row_index_d;
            fill_buf_q  <= fill_buf_d;
            out_row_q   <= out_row_d;
        end
    end

    assign bus.upstream_stall_o = (buf_state_q == BUF_FULL);
    assign bus.out_row_valid_o  = (out_state_q == OUT_HELD);
    assign bus.out_row_o        = out_row_q;
    assign bus.row_index_o      = row_index_q;
    assign bus.last_row_o       = (out_state_q == OUT_HELD) && (row_index_q == IDX_W'(HEIGHT - 1));
endmodule

// File: tb/tb_row_stream_packer.sv
// Directed bench for row_stream_packer (WIDTH=4, HEIGHT=2, IN_CHANNELS=2) with a
// row scoreboard filled from a reference model of the packing order.
module tb_row_stream_packer;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int IC = 2;
    localparam int VB = 8;
    localparam int DB = 32;

    typedef logic [W-1:0][IC-1:0][VB-1:0] row_t;
    typedef struct {
        row_t row;
        int   idx;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cycleCount  = 0;
    int   lastAccept  = 0;
    bit   stallSeen   = 1'b0;

    exp_t sbQueue[$];
    int   hsCycles[$];
    row_t modelRow;
    int   modelCol;
    int   modelCh;
    int   modelIdx;

    row_stream_packer_if #(.WIDTH(W), .HEIGHT(H), .IN_CHANNELS(IC), .VALUE_BITS(VB), .DATA_BITS(DB)) bus ();

    row_stream_packer #(.WIDTH(W), .HEIGHT(H), .IN_CHANNELS(IC), .VALUE_BITS(VB), .DATA_BITS(DB)) dut (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VB-1:0] convertWord(input logic [DB-1:0] w);
`ifdef ROW_PACKER_SATURATE_EN
        if (w[DB-1]) return '0;
        if (w > 32'd255) return 8'hFF;
        return w[VB-1:0];
`else
        return w[VB-1:0];
`endif
    endfunction

    // Every row handshake is scored against the oldest expected row.
    always @(negedge clock) begin
        if (!reset && bus.out_row_valid_o && bus.out_row_ready_i) begin
            hsCycles.push_back(cycleCount);
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected row", 64'(bus.out_row_o), 64'hDEAD);
            end else begin
                exp_t e;
                e = sbQueue.pop_front();
                checkOutput("row data", 64'(bus.out_row_o), 64'(e.row));
                checkOutput("row index", 64'(bus.row_index_o), 64'(e.idx));
                checkOutput("last row", 64'(bus.last_row_o), 64'(e.idx == H - 1));
            end
        end
        if (!reset && bus.upstream_stall_o) stallSeen = 1'b1;
    end

    task automatic modelClear();
        sbQueue.delete();
        hsCycles.delete();
        modelRow = '0;
        modelCol = 0;
        modelCh  = 0;
        modelIdx = 0;
    endtask

    task automatic modelPush(input logic [DB-1:0] w);
        modelRow[modelCol][modelCh] = convertWord(w);
        modelCh++;
        if (modelCh == IC) begin
            modelCh = 0;
            modelCol++;
            if (modelCol == W) begin
                exp_t e;
                modelCol = 0;
                e.row    = modelRow;
                e.idx    = modelIdx;
                sbQueue.push_back(e);
                modelIdx = (modelIdx + 1) % H;
            end
        end
    endtask

    // Drives one word and holds it until the DUT takes it; leaves in_valid high.
    task automatic applyStimulus(input logic [DB-1:0] w);
        bit accepted = 1'b0;
        int waited   = 0;
        bus.in_data_i  = w;
        bus.in_valid_i = 1'b1;
        while (!accepted && waited < 100) begin
            @(negedge clock);
            accepted = !bus.upstream_stall_o;
            @(posedge clock);
            #1;
            waited++;
        end
        if (!accepted) begin
            checkOutput("accept timeout", 64'(waited), 64'(0));
        end else begin
            lastAccept = cycleCount;
            modelPush(w);
        end
    endtask

    task automatic idleCycles(input int n);
        bus.in_valid_i = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic applyReset();
        reset          = 1'b1;
        bus.in_valid_i = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        modelClear();
        stallSeen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, observed hang expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.in_data_i       = '0;
        bus.in_valid_i      = 1'b0;
        bus.out_row_ready_i = 1'b0;
        modelClear();
        applyReset();

        @(negedge clock);
        checkOutput("reset valid", 64'(bus.out_row_valid_o), 64'(0));
        checkOutput("reset stall", 64'(bus.upstream_stall_o), 64'(0));
        checkOutput("reset row", 64'(bus.out_row_o), 64'(0));
        checkOutput("reset index", 64'(bus.row_index_o), 64'(0));
        checkOutput("reset last", 64'(bus.last_row_o), 64'(0));
        @(posedge clock);
        #1;

        // Single row with ready high: valid the cycle after word 7.
        bus.out_row_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) applyStimulus(32'(i));
        idleCycles(3);
        checkOutput("t1 row count", 64'(hsCycles.size()), 64'(1));
        checkOutput("t1 latency", 64'(hsCycles.size() > 0 ? hsCycles[0] : -1), 64'(lastAccept));
        checkOutput("t1 no stall", 64'(stallSeen), 64'(0));

        // Backpressure: two rows held, word 16 stalls until one row drains.
        applyReset();
        bus.out_row_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) applyStimulus(32'(i));
        bus.in_data_i  = 32'h10;
        bus.in_valid_i = 1'b1;
        @(negedge clock);
        checkOutput("t2 stall set", 64'(bus.upstream_stall_o), 64'(1));
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("t2 stall hold", 64'(bus.upstream_stall_o), 64'(1));
        checkOutput("t2 held valid", 64'(bus.out_row_valid_o), 64'(1));
        checkOutput("t2 held index", 64'(bus.row_index_o), 64'(0));
        @(posedge clock);
        #1;
        bus.out_row_ready_i = 1'b1;
        @(posedge clock);
        #1;
        bus.out_row_ready_i = 1'b0;
        @(negedge clock);
        checkOutput("t2 drain valid", 64'(bus.out_row_valid_o), 64'(1));
        checkOutput("t2 drain index", 64'(bus.row_index_o), 64'(1));
        checkOutput("t2 drain last", 64'(bus.last_row_o), 64'(1));
        checkOutput("t2 drain stall", 64'(bus.upstream_stall_o), 64'(0));
        checkOutput("t2 drain row", 64'(bus.out_row_o), 64'h0F0E_0D0C_0B0A_0908);
        checkOutput("t2 drain lane0", 64'(bus.out_row_o[0][0]), 64'h08);
        @(posedge clock);
        #1;
        applyStimulus(32'h10);
        bus.out_row_ready_i = 1'b1;
        idleCycles(3);
        checkOutput("t2 rows out", 64'(hsCycles.size()), 64'(2));

        // Frame wrap with gaps between words: indices 0,1,0.
        applyReset();
        bus.out_row_ready_i = 1'b1;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(32'(8'hA0 + i));
            idleCycles(1);
        end
        idleCycles(3);
        checkOutput("t3 rows out", 64'(hsCycles.size()), 64'(3));

        // Back-to-back words sustain full rate with no stall.
        applyReset();
        bus.out_row_ready_i = 1'b1;
        for (int i = 0; i < 24; i++) applyStimulus(32'(8'h40 + i));
        idleCycles(3);
        checkOutput("t4 rows out", 64'(hsCycles.size()), 64'(3));
        if (hsCycles.size() == 3) begin
            checkOutput("t4 spacing a", 64'(hsCycles[1] - hsCycles[0]), 64'(8));
            checkOutput("t4 spacing b", 64'(hsCycles[2] - hsCycles[1]), 64'(8));
        end
        checkOutput("t4 no stall", 64'(stallSeen), 64'(0));

        // Accept of the held row in the same cycle the next row completes.
        applyReset();
        bus.out_row_ready_i = 1'b0;
        for (int i = 0; i < 15; i++) applyStimulus(32'(8'h60 + i));
        bus.out_row_ready_i = 1'b1;
        applyStimulus(32'h6F);
        bus.out_row_ready_i = 1'b0;
        bus.in_valid_i      = 1'b0;
        @(negedge clock);
        checkOutput("t4b swap valid", 64'(bus.out_row_valid_o), 64'(1));
        checkOutput("t4b swap stall", 64'(bus.upstream_stall_o), 64'(0));
        checkOutput("t4b swap index", 64'(bus.row_index_o), 64'(1));
        checkOutput("t4b swap row", 64'(bus.out_row_o), 64'h6F6E_6D6C_6B6A_6968);
        checkOutput("t4b stall seen", 64'(stallSeen), 64'(0));
        @(posedge clock);
        #1;

        // Reset mid-row discards the partial row.
        applyReset();
        bus.out_row_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(32'(8'h50 + i));
        applyReset();
        for (int i = 0; i < 8; i++) applyStimulus(32'(8'h20 + i));
        idleCycles(3);
        checkOutput("t5 rows out", 64'(hsCycles.size()), 64'(1));

        // Value conversion on out-of-range words.
        applyReset();
        bus.out_row_ready_i = 1'b0;
        applyStimulus(32'hFFFF_FFFF);
        applyStimulus(32'h0000_0123);
        applyStimulus(32'h0000_007F);
        applyStimulus(32'h8000_0000);
        applyStimulus(32'h0000_0100);
        applyStimulus(32'h0000_00FF);
        applyStimulus(32'h0000_0001);
        applyStimulus(32'h0000_0000);
        idleCycles(1);
        @(negedge clock);
`ifdef ROW_PACKER_SATURATE_EN
        checkOutput("t6 lane 0.0", 64'(bus.out_row_o[0][0]), 64'h00);
        checkOutput("t6 lane 0.1", 64'(bus.out_row_o[0][1]), 64'hFF);
        checkOutput("t6 lane 1.1", 64'(bus.out_row_o[1][1]), 64'h00);
`else
        checkOutput("t6 lane 0.0", 64'(bus.out_row_o[0][0]), 64'hFF);
        checkOutput("t6 lane 0.1", 64'(bus.out_row_o[0][1]), 64'h23);
        checkOutput("t6 lane 1.1", 64'(bus.out_row_o[1][1]), 64'h00);
`endif
        checkOutput("t6 lane 1.0", 64'(bus.out_row_o[1][0]), 64'h7F);
        @(posedge clock);
        #1;
        bus.out_row_ready_i = 1'b1;
        idleCycles(3);
        checkOutput("t6 rows out", 64'(hsCycles.size()), 64'(1));
        checkOutput("scoreboard empty", 64'(sbQueue.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
